// File: rtl/step_pulse_pkg.sv
// Shared types and sizing helpers for the step pulse generator.
package step_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  // Bits needed to hold the value max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with a selectable reset level.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; reset forces the idle level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/step_pulse_gen.sv
// Turns the bouncing KEY button and RUN switch into clean one-cycle step pulses:
// debounced press plus auto-repeat in manual mode, fixed-period strobe in run mode.
module step_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int RUN_PERIOD      = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic run_en,
  output logic step,
  output logic key_held,
  output logic running
);

  import step_pulse_pkg::*;

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int RW = cnt_width(RUN_PERIOD);

  localparam logic [DW-1:0] DEB_DONE      = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX      = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST     = HW'(HOLD_CYCLES - 1);
  // A repeat interval longer than the hold time simply restarts from zero.
  localparam logic [HW-1:0] REPEAT_RELOAD =
    HW'((REPEAT_CYCLES >= HOLD_CYCLES) ? 0 : (HOLD_CYCLES - REPEAT_CYCLES));
  localparam logic [RW-1:0] RUN_LAST      = RW'(RUN_PERIOD - 1);

  logic          key_sync_s;
  logic          run_sync_s;
  logic          k_s;
  btn_state_t    state_r, state_nxt_s;
  logic [DW-1:0] dcnt_r, dcnt_nxt_s;
  logic [HW-1:0] hcnt_r, hcnt_nxt_s;
  logic [RW-1:0] rcnt_r;
  logic          btn_fire_s;
  logic          run_wrap_s;
  logic          step_r;
  logic          key_held_r;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_n),
    .q     (key_sync_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_run_sync (
    .clk   (clk),
    .reset (reset),
    .d     (run_en),
    .q     (run_sync_s)
  );

  assign k_s        = ~key_sync_s;
  assign run_wrap_s = run_sync_s && (rcnt_r == RUN_LAST);

  // Button debounce / hold / auto-repeat next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    dcnt_nxt_s  = dcnt_r;
    hcnt_nxt_s  = hcnt_r;
    btn_fire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (k_s) begin
          state_nxt_s = DEB_PRESS;
          dcnt_nxt_s  = DW'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DEB_PRESS: begin
        if (!k_s) begin
          state_nxt_s = IDLE;
        end else if (dcnt_r == DEB_DONE) begin
          state_nxt_s = HELD;
          btn_fire_s  = 1'b1;
          hcnt_nxt_s  = {HW{1'b0}};
        end else begin
          dcnt_nxt_s = dcnt_r + DW'(1);
        end
      end
      HELD: begin
        if (!k_s) begin
          state_nxt_s = DEB_RELEASE;
          dcnt_nxt_s  = DW'(1);
        end else if (REPEAT_CYCLES == 0) begin
          // Auto-repeat disabled: hold time saturates instead of wrapping.
          if (hcnt_r != HOLD_MAX) begin
            hcnt_nxt_s = hcnt_r + HW'(1);
          end else begin
            hcnt_nxt_s = hcnt_r;
          end
        end else if (hcnt_r == HOLD_LAST) begin
          btn_fire_s = 1'b1;
          hcnt_nxt_s = REPEAT_RELOAD;
        end else begin
          hcnt_nxt_s = hcnt_r + HW'(1);
        end
      end
      DEB_RELEASE: begin
        if (k_s) begin
          state_nxt_s = HELD;
        end else if (dcnt_r == DEB_DONE) begin
          state_nxt_s = IDLE;
        end else begin
          dcnt_nxt_s = dcnt_r + DW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Button FSM state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      dcnt_r  <= {DW{1'b0}};
      hcnt_r  <= {HW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      dcnt_r  <= dcnt_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
    end
  end

  // Run-mode period counter; held at zero whenever run mode is off.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_r <= {RW{1'b0}};
    end else if (!run_sync_s || run_wrap_s) begin
      rcnt_r <= {RW{1'b0}};
    end else begin
      rcnt_r <= rcnt_r + RW'(1);
    end
  end

  // Registered outputs; run mode masks button pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r     <= 1'b0;
      key_held_r <= 1'b0;
    end else begin
      step_r     <= run_sync_s ? run_wrap_s : btn_fire_s;
      key_held_r <= (state_nxt_s == HELD) || (state_nxt_s == DEB_RELEASE);
    end
  end

  assign step     = step_r;
  assign key_held = key_held_r;
  assign running  = run_sync_s;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: per-cycle vectors with hand-computed
// step / key_held / running expectations.
module tb_step_pulse_gen;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic run_en;
  logic step;
  logic key_held;
  logic running;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8),
    .REPEAT_CYCLES   (3),
    .RUN_PERIOD      (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .run_en   (run_en),
    .step     (step),
    .key_held (key_held),
    .running  (running)
  );

  task automatic check_val(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = {64{1'b0}};
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] at(input int k);
    logic [63:0] m;
    m = {64{1'b0}};
    m[k] = 1'b1;
    return m;
  endfunction

  // Bit r of press/run/rst is driven just after edge r; bit e of the
  // expectation masks is the output value just after edge e.
  task automatic run_vec(input string tag, input int n,
                         input logic [63:0] press, input logic [63:0] run,
                         input logic [63:0] rst, input logic [63:0] exp_step,
                         input logic [63:0] exp_held, input logic [63:0] exp_run);
    for (int r = 0; r < n; r++) begin
      key_n  = ~press[r];
      run_en = run[r];
      reset  = rst[r];
      @(posedge clk);
      #1;
      check_val($sformatf("%s.step@%0d", tag, r + 1), step, exp_step[r + 1]);
      check_val($sformatf("%s.held@%0d", tag, r + 1), key_held, exp_held[r + 1]);
      check_val($sformatf("%s.run@%0d", tag, r + 1), running, exp_run[r + 1]);
    end
    key_n  = 1'b1;
    run_en = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    key_n  = 1'b1;
    run_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.step", step, 1'b0);
    check_val("reset.held", key_held, 1'b0);
    check_val("reset.run", running, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Clean press of 6 cycles.
    run_vec("clean", 20, rng(0, 5), 64'd0, 64'd0,
            at(7), rng(7, 12), 64'd0);

    // Bouncing press, only the final run of lows is long enough.
    run_vec("bouncy", 25, rng(0, 1) | rng(3, 4) | rng(6, 11), 64'd0, 64'd0,
            at(13), rng(13, 18), 64'd0);

    // Long hold: press pulse then repeats at +8, then every 3.
    run_vec("repeat", 40, rng(0, 29), 64'd0, 64'd0,
            at(7) | at(15) | at(18) | at(21) | at(24) | at(27) | at(30),
            rng(7, 36), 64'd0);

    // Release bounce in HELD: hold count resumes where it left off.
    run_vec("relbounce", 30, rng(0, 9) | rng(12, 19), 64'd0, 64'd0,
            at(7) | at(18) | at(21), rng(7, 26), 64'd0);

    // Run mode with a button press inside it, then a restart.
    run_vec("runmode", 42, rng(3, 13), rng(0, 24) | rng(30, 34), 64'd0,
            at(7) | at(12) | at(17) | at(22) | at(27) | at(37),
            rng(10, 20), rng(2, 26) | rng(32, 36));

    // One-cycle reset while held; button re-debounced afterwards.
    run_vec("rsthold", 30, rng(0, 19), 64'd0, at(10),
            at(7) | at(18), rng(7, 10) | rng(18, 26), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Upstream stage of the double-digit generation counter display; produces its single-cycle count strobe.
- Turns the raw, bouncing, asynchronous KEY button (active-low) and the RUN slide switch into clean one-clock step pulses.
- Manual mode: one pulse per debounced press, plus auto-repeat while held.
- Run mode: free-running pulse every RUN_PERIOD cycles.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a press or release (>=1)
HOLD_CYCLES, 25000000, cycles a press must be held before the first auto-repeat pulse (>=1)
REPEAT_CYCLES, 5000000, cycles between auto-repeat pulses; 0 disables auto-repeat
RUN_PERIOD, 50000000, cycles between pulses in run mode (>=2)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high
key_n  input  1  raw push-button, active-low, asynchronous, bouncing
run_en  input  1  raw slide switch, asynchronous; 1 = run mode
step  output  1  registered one-cycle pulse, drives the counter display's count input
key_held  output  1  registered debounced button state (1 = pressed)
running  output  1  registered synchronized run_en

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state is updated on posedge clk only.
- Reset values: step=0, key_held=0, running=0, FSM=IDLE, all counters 0, synchronizer flops = released (key 1, run 0).
- Synchronizers: key_n and run_en each pass through SYNC_STAGES flops. k = inverted synchronized key_n (1 = pressed).
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
  - IDLE: k=1 -> DEB_PRESS, dcnt=1.
  - DEB_PRESS: k=0 -> IDLE. k=1 and dcnt==DEBOUNCE_CYCLES -> HELD, fire press pulse, hcnt=0. Otherwise dcnt++.
  - HELD: k=0 -> DEB_RELEASE, dcnt=1. Otherwise hcnt++.
    - Fire a repeat pulse when hcnt reaches HOLD_CYCLES.
    - Then fire again every REPEAT_CYCLES cycles (hcnt reloads to HOLD_CYCLES-REPEAT_CYCLES).
    - No repeat pulses when REPEAT_CYCLES=0.
  - DEB_RELEASE: k=1 -> HELD, no pulse, hcnt keeps its value. k=0 and dcnt==DEBOUNCE_CYCLES -> IDLE. Otherwise dcnt++.
- key_held = 1 in HELD and DEB_RELEASE, else 0; registered.
- Press latency: key_n held low from edge E -> step high for exactly one cycle at edge E+SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Run mode (running=1):
  - Period counter rcnt counts 0..RUN_PERIOD-1 and wraps; step fires on the cycle rcnt wraps to 0.
  - rcnt clears on the 0->1 transition of running, so the first pulse comes RUN_PERIOD cycles after running rises.
  - While running=1, the button FSM keeps tracking (key_held valid) but its pulses are suppressed.
  - Falling running: rcnt cleared, no further run pulses from the next cycle.
- Simultaneous events: at most one step pulse per cycle. Button and run sources are mutually exclusive by mode, so no merging or queuing.
- Reset mid-operation: everything returns to reset values on the next edge.
  - A button still held through reset is re-synchronized and re-debounced.
  - It generates a fresh pulse at the normal press latency after reset deasserts.
- Counter widths are $clog2(max+1) of the respective parameter; no counter may overflow or wrap except rcnt.

Decomposition:
- Package step_pulse_pkg: state enum typedef (IDLE, DEB_PRESS, HELD, DEB_RELEASE) and a width-helper function for counter sizing.
- Sub-module sync_bit: SYNC_STAGES-deep single-bit synchronizer with parameterized reset value. Instantiated twice (key_n reset 1, run_en reset 0).

Test Plan:
Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3, RUN_PERIOD=5.
1. Clean press: key_n low at edge 10 for 6 cycles, then high -> exactly one step, at edge 17. key_held rises with it and falls after release debounce. No other pulses.
2. Bouncy press: key_n low 2 cycles, high 1, low 2, high 1, then low held 6 -> no step until 4 consecutive synchronized low samples; exactly one step total.
3. Auto-repeat: key_n held low 30 cycles -> steps at T, T+8, T+11, T+14, ... while held. None after release debounce completes.
4. Release bounce: in HELD, key_n high 2 cycles then low again -> state returns to HELD, key_held stays 1, no extra step.
5. Run mode: run_en high at edge 0 -> running=1 at edge 2, steps every 5 cycles. Button presses meanwhile give no pulses. run_en low -> pulses stop within SYNC_STAGES+1 cycles.
6. Reset mid-hold: assert reset one cycle while in HELD with key_n low -> step=0, key_held=0 next edge. With key_n still low, one new step at 7 edges after reset deasserts.
